// File: rtl/ledg_fader.sv
// LED afterglow fader.
// Each channel snaps to full brightness while its raw input is high. Once the
// input drops, the channel decays one level per fade tick. The output is a
// PWM drive whose duty cycle follows the channel level. All channels share one
// PWM counter and one fade prescaler, but their levels are independent.
module ledg_fader #(
    parameter int unsigned N_LED    = 10,
    parameter int unsigned PWM_BITS = 4,
    // Number of PWM periods per one-step decay. Must be in 1..65535.
    parameter int unsigned FADE_DIV = 1024
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [N_LED-1:0] iLED,
    input  logic             iEN,
    output logic [N_LED-1:0] oLED,
    output logic             oACTIVE
);

    localparam logic [PWM_BITS-1:0] LVL_MAX   = {PWM_BITS{1'b1}};
    localparam logic [15:0]         FADE_LAST = 16'(FADE_DIV - 1);

    // Synchronizer stages for the raw LED pattern.
    logic [N_LED-1:0] s1;
    logic [N_LED-1:0] s2;

    // Free-running PWM phase and the fade prescaler.
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_wrap;
    logic [15:0]         fade_cnt;
    logic [15:0]         fade_cnt_next;
    logic                fade_tick;

    // Per-channel brightness levels.
    logic [N_LED-1:0][PWM_BITS-1:0] lvl;
    logic [N_LED-1:0][PWM_BITS-1:0] lvl_next;

    logic [N_LED-1:0] led_next;
    logic             active_next;

    // Two-flop synchronizer: iLED is asynchronous to iCLK.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= iLED;
            s2 <= s1;
        end
    end

    // PWM counter runs every clock, even while disabled, so the PWM phase
    // stays continuous across enable changes.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    assign pwm_wrap = (pwm_cnt == LVL_MAX);

    // Fade prescaler: counts PWM periods while enabled; the tick fires on the
    // last clock of the FADE_DIV-th period and the count wraps back to zero.
    always_comb begin
        fade_tick     = pwm_wrap && iEN && (fade_cnt == FADE_LAST);
        fade_cnt_next = fade_cnt;
        if (pwm_wrap && iEN) begin
            fade_cnt_next = fade_tick ? 16'd0 : fade_cnt + 16'd1;
        end
    end

    // Prescaler register; holds its value while iEN is low.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            fade_cnt <= '0;
        end else begin
            fade_cnt <= fade_cnt_next;
        end
    end

    // Level update: a live input reloads full brightness and wins over a
    // coincident fade tick; decay saturates at zero. Loads ignore iEN.
    always_comb begin
        lvl_next = lvl;
        for (int i = 0; i < int'(N_LED); i++) begin
            if (s2[i]) begin
                lvl_next[i] = LVL_MAX;
            end else if (fade_tick && (lvl[i] != '0)) begin
                lvl_next[i] = lvl[i] - 1'b1;
            end
        end
    end

    // Level registers.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            lvl <= '0;
        end else begin
            lvl <= lvl_next;
        end
    end

    // PWM compare: full level is solid on, otherwise on for the first lvl
    // clocks of each period; everything blanks while disabled.
    always_comb begin
        led_next = '0;
        for (int i = 0; i < int'(N_LED); i++) begin
            led_next[i] = iEN && ((lvl[i] == LVL_MAX) || (pwm_cnt < lvl[i]));
        end
        active_next = |lvl;
    end

    // Registered outputs.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oLED    <= '0;
            oACTIVE <= 1'b0;
        end else begin
            oLED    <= led_next;
            oACTIVE <= active_next;
        end
    end

endmodule

// File: tb/tb_ledg_fader.sv
// Directed bench for ledg_fader with PWM_BITS=4, FADE_DIV=2 (fade tick every
// 32 clocks, ticks at edges 32, 64, ... counted from reset release).
module tb_ledg_fader;

    localparam int unsigned N_LED    = 10;
    localparam int unsigned PWM_BITS = 4;
    localparam int unsigned FADE_DIV = 2;

    logic             iCLK;
    logic             iRST;
    logic [N_LED-1:0] iLED;
    logic             iEN;
    logic [N_LED-1:0] oLED;
    logic             oACTIVE;

    int n_cmp = 0;
    int n_bad = 0;

    ledg_fader #(
        .N_LED    (N_LED),
        .PWM_BITS (PWM_BITS),
        .FADE_DIV (FADE_DIV)
    ) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iLED    (iLED),
        .iEN     (iEN),
        .oLED    (oLED),
        .oACTIVE (oACTIVE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Advance n rising edges, then settle 2 time units past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge iCLK);
        #2;
    endtask

    // Asynchronous reset pulse between clock edges; next edge is edge 1.
    task automatic pulse_reset();
        iRST = 1'b1;
        #1;
        iRST = 1'b0;
    endtask

    task automatic test_reset();
        iEN  = 1'b1;
        iLED = '1;
        edges(1);
        pulse_reset();
        edges(8);
        n_cmp++;
        if (oLED !== 10'h3FF) begin
            n_bad++;
            $display("FAIL reset_pre_on: oLED=%h expected 3ff", oLED);
        end
        // Mid-run async reset: outputs must clear without a clock edge.
        iRST = 1'b1;
        #1;
        n_cmp++;
        if (oLED !== 10'h000 || oACTIVE !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async_out: oLED=%h oACTIVE=%b expected 000/0", oLED, oACTIVE);
        end
        n_cmp++;
        if (dut.lvl !== '0 || dut.pwm_cnt !== 4'd0 || dut.fade_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_async_state: lvl=%h pwm=%0d fade=%0d expected 0/0/0",
                     dut.lvl, dut.pwm_cnt, dut.fade_cnt);
        end
        iRST = 1'b0;
        edges(1);
        n_cmp++;
        if (dut.pwm_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL reset_first_inc: pwm_cnt=%0d expected 1", dut.pwm_cnt);
        end
        edges(2);
        n_cmp++;
        if (oLED !== 10'h000 || dut.lvl[5] !== 4'd15) begin
            n_bad++;
            $display("FAIL reset_edge3: oLED=%h lvl5=%0d expected 000/15", oLED, dut.lvl[5]);
        end
        edges(1);
        n_cmp++;
        if (oLED !== 10'h3FF || oACTIVE !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_edge4: oLED=%h oACTIVE=%b expected 3ff/1", oLED, oACTIVE);
        end
    endtask

    task automatic test_fade();
        int highs;
        iEN  = 1'b1;
        iLED = '0;
        pulse_reset();
        iLED = 10'h001;
        edges(3);
        n_cmp++;
        if (dut.lvl[0] !== 4'd15 || oLED !== 10'h000) begin
            n_bad++;
            $display("FAIL fade_load: lvl0=%0d oLED=%h expected 15/000", dut.lvl[0], oLED);
        end
        edges(1);
        n_cmp++;
        if (oLED !== 10'h001 || oACTIVE !== 1'b1) begin
            n_bad++;
            $display("FAIL fade_on: oLED=%h oACTIVE=%b expected 001/1", oLED, oACTIVE);
        end
        edges(4);
        iLED = '0;
        edges(23);
        n_cmp++;
        if (dut.lvl[0] !== 4'd15) begin
            n_bad++;
            $display("FAIL fade_hold31: lvl0=%0d expected 15", dut.lvl[0]);
        end
        edges(1);
        n_cmp++;
        if (dut.lvl[0] !== 4'd14) begin
            n_bad++;
            $display("FAIL fade_step32: lvl0=%0d expected 14", dut.lvl[0]);
        end
        highs = 0;
        for (int c = 0; c < 16; c++) begin
            edges(1);
            if (oLED[0] === 1'b1) highs++;
        end
        n_cmp++;
        if (highs != 14) begin
            n_bad++;
            $display("FAIL fade_duty14: high clocks=%0d expected 14", highs);
        end
        edges(431);
        n_cmp++;
        if (dut.lvl[0] !== 4'd1) begin
            n_bad++;
            $display("FAIL fade_e479: lvl0=%0d expected 1", dut.lvl[0]);
        end
        edges(1);
        n_cmp++;
        if (dut.lvl[0] !== 4'd0 || oACTIVE !== 1'b1) begin
            n_bad++;
            $display("FAIL fade_e480: lvl0=%0d oACTIVE=%b expected 0/1", dut.lvl[0], oACTIVE);
        end
        edges(1);
        n_cmp++;
        if (oACTIVE !== 1'b0 || oLED !== 10'h000) begin
            n_bad++;
            $display("FAIL fade_e481: oACTIVE=%b oLED=%h expected 0/000", oACTIVE, oLED);
        end
    endtask

    task automatic test_priority();
        iEN  = 1'b1;
        iLED = 10'b00_0001_1000;
        pulse_reset();
        edges(1);
        iLED = '0;
        edges(348);
        iLED = 10'h008;
        edges(1);
        iLED = '0;
        edges(1);
        n_cmp++;
        if (dut.lvl[3] !== 4'd5 || dut.lvl[4] !== 4'd5 || dut.s2[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL prio_pre: lvl3=%0d lvl4=%0d s2_3=%b expected 5/5/1",
                     dut.lvl[3], dut.lvl[4], dut.s2[3]);
        end
        edges(1);
        n_cmp++;
        if (dut.lvl[3] !== 4'd15) begin
            n_bad++;
            $display("FAIL prio_load_wins: lvl3=%0d expected 15", dut.lvl[3]);
        end
        n_cmp++;
        if (dut.lvl[4] !== 4'd4) begin
            n_bad++;
            $display("FAIL prio_neighbour: lvl4=%0d expected 4", dut.lvl[4]);
        end
    endtask

    task automatic test_enable();
        int highs;
        iEN  = 1'b1;
        iLED = 10'h002;
        pulse_reset();
        edges(1);
        iLED = '0;
        edges(199);
        n_cmp++;
        if (dut.lvl[1] !== 4'd9 || oLED[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL en_pre: lvl1=%0d oLED1=%b expected 9/1", dut.lvl[1], oLED[1]);
        end
        iEN   = 1'b0;
        highs = 0;
        for (int c = 0; c < 100; c++) begin
            edges(1);
            if (oLED !== 10'h000) highs++;
        end
        n_cmp++;
        if (highs != 0) begin
            n_bad++;
            $display("FAIL en_blank: clocks with oLED set=%0d expected 0", highs);
        end
        n_cmp++;
        if (dut.lvl[1] !== 4'd9 || dut.fade_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL en_frozen: lvl1=%0d fade_cnt=%0d expected 9/0",
                     dut.lvl[1], dut.fade_cnt);
        end
        iEN = 1'b1;
        edges(4);
        highs = 0;
        for (int c = 0; c < 16; c++) begin
            edges(1);
            if (oLED[1] === 1'b1) highs++;
        end
        n_cmp++;
        if (highs != 9) begin
            n_bad++;
            $display("FAIL en_duty9: high clocks=%0d expected 9", highs);
        end
        n_cmp++;
        if (dut.lvl[1] !== 4'd8) begin
            n_bad++;
            $display("FAIL en_resume: lvl1=%0d expected 8 at edge 320", dut.lvl[1]);
        end
    endtask

    task automatic test_walk();
        int pos [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5};
        // Last pattern step at which each channel was lit.
        int last [10] = '{0, 1, 2, 3, 4, 9, 9, 9, 8, 7};
        logic [N_LED-1:0][PWM_BITS-1:0] lvl_prev;
        logic [N_LED-1:0] pat;
        int viol;
        int exp_lvl;
        iEN  = 1'b1;
        iLED = '0;
        pulse_reset();
        viol = 0;
        for (int k = 0; k < 10; k++) begin
            pat  = 10'b00_0000_0111;
            iLED = pat << pos[k];
            for (int c = 0; c < 64; c++) begin
                lvl_prev = dut.lvl;
                edges(1);
                for (int i = 0; i < 10; i++) begin
                    if (oLED[i] === 1'b1 && lvl_prev[i] == 4'd0) viol++;
                end
            end
        end
        iLED = '0;
        edges(40);
        n_cmp++;
        if (viol != 0) begin
            n_bad++;
            $display("FAIL walk_dark: lit-at-zero events=%0d expected 0", viol);
        end
        // At edge 680 (21 ticks so far) level = 15 - 21 + 2*(last+1), floor 0.
        for (int i = 0; i < 10; i++) begin
            exp_lvl = 15 - 21 + 2 * (last[i] + 1);
            if (exp_lvl < 0) exp_lvl = 0;
            n_cmp++;
            if (dut.lvl[i] !== 4'(exp_lvl)) begin
                n_bad++;
                $display("FAIL walk_lvl%0d: lvl=%0d expected %0d", i, dut.lvl[i], exp_lvl);
            end
        end
        n_cmp++;
        if (oACTIVE !== 1'b1) begin
            n_bad++;
            $display("FAIL walk_active: oACTIVE=%b expected 1", oACTIVE);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iRST = 1'b0;
        iLED = '0;
        iEN  = 1'b1;
        test_reset();
        test_fade();
        test_priority();
        test_enable();
        test_walk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ledg_fader.md
LEDG_FADER -- requirements
Module: ledg_fader

Interface
REQ-001 Parameter N_LED, default 10: number of LED channels.
REQ-002 Parameter PWM_BITS, default 4: PWM counter and brightness level width; PWM period is 2^PWM_BITS clocks.
REQ-003 Parameter FADE_DIV, default 1024: PWM periods per one-step brightness decay; legal range 1..65535.
REQ-004 Port iCLK, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port iRST, input, 1: reset, asynchronous, active-high.
REQ-006 Port iLED, input, N_LED: raw LED pattern from the upstream LED driver, asynchronous to iCLK.
REQ-007 Port iEN, input, 1: 1 = normal operation; 0 = outputs blanked and fading frozen.
REQ-008 Port oLED, output, N_LED: PWM-dimmed LED drive, registered.
REQ-009 Port oACTIVE, output, 1: registered; 1 while any channel level is non-zero.

Function
REQ-010 iLED SHALL pass through a 2-flop synchronizer per bit (s1, s2) before any use.
REQ-011 pwm_cnt (PWM_BITS wide) SHALL increment every clock and wrap from 2^PWM_BITS-1 to 0.
REQ-012 fade_cnt (16 bits) SHALL increment when pwm_cnt == max and iEN == 1; it SHALL wrap from FADE_DIV-1 to 0.
REQ-013 fade_tick SHALL be high for exactly one clock: when pwm_cnt == max, fade_cnt == FADE_DIV-1 and iEN == 1.
REQ-014 Per channel, lvl[i] (PWM_BITS wide): if s2[i] == 1, load max (all ones).
REQ-015 Otherwise, on fade_tick with lvl[i] > 0, decrement by 1.
REQ-016 Otherwise, hold.
REQ-017 s2[i] == 1 SHALL take priority over fade_tick in the same cycle.
REQ-018 lvl[i] SHALL saturate at 0; it SHALL never wrap below 0.
REQ-019 lvl[i] loads SHALL occur regardless of iEN.
REQ-020 oLED[i] SHALL be registered as 1 iff iEN == 1 and (lvl[i] == max or pwm_cnt < lvl[i]); lvl == max is solid on, lvl == 0 is solid off.
REQ-021 Duty for 0 < lvl < max SHALL be exactly lvl/2^PWM_BITS of each PWM period.
REQ-022 Latency: a steady iLED[i] rise before edge k SHALL give lvl[i] == max after edge k+2 and oLED[i] == 1 after edge k+3, provided iEN == 1.
REQ-023 Full fade from max to 0 SHALL take exactly (2^PWM_BITS-1) fade_ticks, i.e. (2^PWM_BITS-1)*FADE_DIV*2^PWM_BITS clocks with iEN held 1.
REQ-024 iEN falling SHALL force oLED to 0 on the next edge; pwm_cnt keeps running; fade_cnt and levels (except loads) freeze.
REQ-025 On iEN rising, fade SHALL resume from the frozen fade_cnt value.
REQ-026 oACTIVE SHALL be registered as the OR of all lvl[i] != 0, one clock behind lvl.
REQ-027 Channels SHALL be fully independent; a load on one channel SHALL NOT affect any other channel's level or fade phase.

Reset
REQ-028 iRST high SHALL asynchronously clear s1, s2, pwm_cnt, fade_cnt, all lvl, oLED and oACTIVE to 0, regardless of iCLK.
REQ-029 Reset mid-fade SHALL discard all levels; after release, fading SHALL restart only from fresh iLED loads.
REQ-030 First pwm_cnt increment SHALL occur on the first rising edge after iRST deasserts.

Verification (PWM_BITS=4, FADE_DIV=2)
REQ-031 Reset: pulse iRST between clock edges with iLED=10'h3FF -> oLED=0 and oACTIVE=0 immediately; after release, oLED=10'h3FF on the 4th edge.
REQ-032 Load/fade: iLED[0] 1 for 8 clocks then 0 -> lvl[0] goes 15,14,...,0, one step per 32 clocks; oLED[0] duty 14/16 in the period after the first decrement; total fade 480 clocks; oACTIVE falls 1 clock after lvl[0]==0.
REQ-033 Priority: assert s2[3] on the exact cycle fade_tick fires with lvl[3]=5 -> lvl[3]=15, not 4.
REQ-034 Enable: drop iEN at lvl=9 for 100 clocks -> oLED=0 throughout, lvl stays 9; on re-enable, duty 9/16 and the remaining fade timing is unchanged.
REQ-035 Walking pattern: drive the 3-bit bouncing pattern, one shift per 64 clocks -> each trailing LED decays independently; no level underflow; oLED never high when lvl==0.
